// File: rtl/legv8_pkg.sv
// legv8_pkg
// Shared LEGv8 encoding constants: operation enum, R/D 11-bit opcodes,
// CB 8-bit and B 6-bit opcodes, immediate field widths, the loader state
// enum and an immediate range helper. The opcode values are the same ones
// the Controller decodes, so encoder and decoder cannot drift apart.
package legv8_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_ORR  = 3'd3,
    OP_LDUR = 3'd4,
    OP_STUR = 3'd5,
    OP_CBZ  = 3'd6,
    OP_B    = 3'd7
  } op_e;

  // Instruction word bits [31:21] for R and D formats
  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  // CB opcode occupies [31:24], B opcode occupies [31:26]
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
  localparam logic [5:0]  OPC_B    = 6'b000101;

  // Signed immediate field widths (word offsets for CB/B)
  localparam int unsigned DT_IMM_W = 9;
  localparam int unsigned CB_IMM_W = 19;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2,
    ST_FULL = 2'd3
  } load_state_e;

  // True when imm equals the sign-extension of its low n bits: every bit
  // from n-1 upward must be identical, so an arithmetic shift by n-1
  // leaves either all zeros or all ones.
  function automatic logic imm_fits(logic [25:0] imm, int unsigned n);
    logic signed [25:0] hi;
    hi = $signed(imm) >>> (n - 1);
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/instr_encoder_loader_if.sv
// instr_encoder_loader_if
// Bundles the field-bundle stream (start, valid/ready, op and fields),
// the instruction-memory write port and the load status flags.
//   master : producer of field bundles / consumer of memory writes (bench, boot logic)
//   slave  : the encoder-loader itself
// ADDR_W must match the ADDR_W of the attached instr_encoder_loader.
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [4:0]        in_rd;
  logic [4:0]        in_rn;
  logic [4:0]        in_rm;
  logic [25:0]       in_imm;
  logic              in_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W-1:0] count;
  logic              done;
  logic              err_range;
  logic              err_full;

  modport master (
    output start, in_valid, in_op, in_rd, in_rn, in_rm, in_imm, in_last,
    input  in_ready, imem_we, imem_addr, imem_wdata, count, done, err_range, err_full
  );

  modport slave (
    input  start, in_valid, in_op, in_rd, in_rn, in_rm, in_imm, in_last,
    output in_ready, imem_we, imem_addr, imem_wdata, count, done, err_range, err_full
  );
endinterface

// File: rtl/instr_field_packer.sv
// instr_field_packer
// Combinational LEGv8 encoder: packs op + register fields + immediate into
// a 32-bit machine word and reports whether the immediate fits its field.
//   op       : operation to encode
//   rd/rn/rm : Rd/Rt, Rn, Rm register numbers
//   imm      : signed immediate (DT 9b, CB 19b, B 26b)
//   word     : encoded instruction
//   range_ok : immediate fits (always 1 for R-type and B)
module instr_field_packer
  import legv8_pkg::*;
(
  input  op_e         op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rn,
  input  logic [4:0]  rm,
  input  logic [25:0] imm,
  output logic [31:0] word,
  output logic        range_ok
);

  always_comb begin
    // NOTE: every output gets a value before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    word     = '0;
    range_ok = 1'b1;
    case (op)
      OP_ADD:  word = {OPC_ADD, rm, 6'b0, rn, rd};
      OP_SUB:  word = {OPC_SUB, rm, 6'b0, rn, rd};
      OP_AND:  word = {OPC_AND, rm, 6'b0, rn, rd};
      OP_ORR:  word = {OPC_ORR, rm, 6'b0, rn, rd};
      OP_LDUR: begin
        word     = {OPC_LDUR, imm[8:0], 2'b00, rn, rd};
        range_ok = imm_fits(imm, DT_IMM_W);
      end
      OP_STUR: begin
        word     = {OPC_STUR, imm[8:0], 2'b00, rn, rd};
        range_ok = imm_fits(imm, DT_IMM_W);
      end
      OP_CBZ: begin
        word     = {OPC_CBZ, imm[18:0], rd};
        range_ok = imm_fits(imm, CB_IMM_W);
      end
      // B uses the full 26-bit immediate, so it always fits
      OP_B:    word = {OPC_B, imm};
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
// Accepts decoded LEGv8 field bundles over a valid/ready stream, encodes
// them and writes the words to consecutive instruction-memory locations.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : stream in, imem write port out, count/done/err flags out
// A bundle accepted at edge N is written during cycle N+1 at the current
// imem_addr; address and count advance at the end of that write cycle.
module instr_encoder_loader
  import legv8_pkg::*;
#(
  parameter int IMEM_WORDS = 64,
  parameter int ADDR_W     = 8
) (
  input logic                   clk,
  input logic                   reset,
  instr_encoder_loader_if.slave bus
);

  load_state_e       state_q, state_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic              done_q, done_d;
  logic              err_range_q, err_range_d;
  logic              err_full_q, err_full_d;

  logic [31:0]       word;
  logic              range_ok;
  logic              accept;
  logic              final_word;

  instr_field_packer u_packer (
    .op       (op_e'(bus.in_op)),
    .rd       (bus.in_rd),
    .rn       (bus.in_rn),
    .rm       (bus.in_rm),
    .imm      (bus.in_imm),
    .word     (word),
    .range_ok (range_ok)
  );

  // start wins over a bundle presented in the same cycle
  assign accept = (state_q == ST_LOAD) && bus.in_valid && !bus.start;

  // Words already committed = count plus the write still in flight; this
  // bundle fills memory when that total is one short of capacity.
  assign final_word = (count_q + ADDR_W'(we_q)) == ADDR_W'(IMEM_WORDS - 1);

  always_comb begin
    state_d     = state_q;
    we_d        = 1'b0;
    wdata_d     = wdata_q;
    addr_d      = addr_q;
    count_d     = count_q;
    done_d      = done_q;
    err_range_d = err_range_q;
    err_full_d  = err_full_q;

    // Retire the write that is on the bus this cycle
    if (we_q) begin
      addr_d  = addr_q + ADDR_W'(4);
      count_d = count_q + ADDR_W'(1);
    end

    if (bus.start) begin
      state_d     = ST_LOAD;
      addr_d      = '0;
      count_d     = '0;
      done_d      = 1'b0;
      err_range_d = 1'b0;
      err_full_d  = 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (accept) begin
            if (!range_ok) begin
              err_range_d = 1'b1;
            end else begin
              we_d    = 1'b1;
              wdata_d = word;
              // Leave LOAD at the accept edge so in_ready drops during the write
              if (bus.in_last) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
              end else if (final_word) begin
                state_d    = ST_FULL;
                err_full_d = 1'b1;
              end
            end
          end
        end
        default: ;  // IDLE, DONE, FULL wait for start
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the values from before this edge.
    if (reset) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      addr_q      <= '0;
      count_q     <= '0;
      done_q      <= 1'b0;
      err_range_q <= 1'b0;
      err_full_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      done_q      <= done_d;
      err_range_q <= err_range_d;
      err_full_q  <= err_full_d;
    end
  end

  assign bus.in_ready   = (state_q == ST_LOAD);
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.count      = count_q;
  assign bus.done       = done_q;
  assign bus.err_range  = err_range_q;
  assign bus.err_full   = err_full_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader
// Self-checking bench: directed vector table, hand-written multi-cycle
// sequences (reset, restart, fill to capacity on a 4-word instance) and a
// randomized phase against an arithmetic reference encoder and a queue of
// expected memory writes.
module tb_instr_encoder_loader;

  localparam int AW    = 8;
  localparam int WORDS = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_encoder_loader_if #(.ADDR_W(AW)) ifc ();
  instr_encoder_loader_if #(.ADDR_W(AW)) ifc4 ();

  instr_encoder_loader #(.IMEM_WORDS(WORDS), .ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  instr_encoder_loader #(.IMEM_WORDS(4), .ADDR_W(AW)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc4.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int opc11 [6] = '{'h458, 'h658, 'h450, 'h550, 'h7C2, 'h7C0};

  function automatic logic [31:0] ref_encode(int op, int rd, int rn, int rm, int imm,
                                             output bit ok);
    longint w;
    ok = 1'b1;
    w  = 0;
    case (op)
      0, 1, 2, 3: w = longint'(opc11[op]) * 2097152 + longint'(rm) * 65536 + rn * 32 + rd;
      4, 5: begin
        ok = (imm >= -256) && (imm <= 255);
        w  = longint'(opc11[op]) * 2097152 + longint'(imm & 511) * 4096 + rn * 32 + rd;
      end
      6: begin
        ok = (imm >= -262144) && (imm <= 262143);
        w  = longint'(180) * 16777216 + longint'(imm & 'h7FFFF) * 32 + rd;
      end
      default: w = longint'(5) * 67108864 + longint'(imm & 'h3FFFFFF);
    endcase
    return 32'(w);
  endfunction

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  bit  m_load, m_done, m_err_range, m_err_full;
  int  m_count;
  int  w4 = 0;

  task automatic model_clear();
    m_count     = 0;
    m_done      = 1'b0;
    m_err_range = 1'b0;
    m_err_full  = 1'b0;
  endtask

  // Every write seen on the main instance must be the oldest expected one
  always @(negedge clk) begin : monitor
    wr_t e;
    if (ifc.imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                 ifc.imem_addr, ifc.imem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", 32'(ifc.imem_addr), e.addr);
        check("write_data", ifc.imem_wdata, e.data);
      end
    end
    if (ifc4.imem_we === 1'b1) w4++;
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic put_fields(int op, int rd, int rn, int rm, int imm, bit last);
    ifc.in_op   = 3'(op);
    ifc.in_rd   = 5'(rd);
    ifc.in_rn   = 5'(rn);
    ifc.in_rm   = 5'(rm);
    ifc.in_imm  = 26'(imm);
    ifc.in_last = last;
  endtask

  task automatic send(int op, int rd, int rn, int rm, int imm, bit last,
                      logic [31:0] word, bit ok);
    logic [AW-1:0] a;
    ifc.in_valid = 1'b1;
    put_fields(op, rd, rn, rm, imm, last);
    check("in_ready", 32'(ifc.in_ready), 32'(m_load));
    if (m_load) begin
      if (ok) begin
        a = AW'(4 * m_count);
        exp_q.push_back('{32'(a), word});
        m_count++;
        if (last) begin
          m_done = 1'b1;
          m_load = 1'b0;
        end else if (m_count == WORDS) begin
          m_err_full = 1'b1;
          m_load     = 1'b0;
        end
      end else begin
        m_err_range = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_model(int op, int rd, int rn, int rm, int imm, bit last);
    bit ok;
    logic [31:0] w;
    w = ref_encode(op, rd, rn, rm, imm, ok);
    send(op, rd, rn, rm, imm, last, w, ok);
  endtask

  task automatic idle(int n);
    ifc.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic check_status(string tag);
    logic [AW-1:0] a;
    a = AW'(4 * m_count);
    check({tag, "_count"},     32'(ifc.count),     32'(AW'(m_count)));
    check({tag, "_addr"},      32'(ifc.imem_addr), 32'(a));
    check({tag, "_done"},      32'(ifc.done),      32'(m_done));
    check({tag, "_err_range"}, 32'(ifc.err_range), 32'(m_err_range));
    check({tag, "_err_full"},  32'(ifc.err_full),  32'(m_err_full));
    check({tag, "_in_ready"},  32'(ifc.in_ready),  32'(m_load));
  endtask

  // start pulse, optionally with a bundle that must be dropped
  task automatic do_start(bit with_bundle);
    ifc.start    = 1'b1;
    ifc.in_valid = with_bundle;
    put_fields($urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 31),
               $urandom_range(0, 31), 0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    ifc.start    = 1'b0;
    ifc.in_valid = 1'b0;
    model_clear();
    m_load = 1'b1;
  endtask

  function automatic int pick_imm(int n);
    int lo, hi, k;
    lo = -(1 << (n - 1));
    hi = (1 << (n - 1)) - 1;
    k  = $urandom_range(0, 5);
    if (k == 0) return lo;
    if (k == 1) return hi;
    if (k == 2 && n < 26) return lo - 1;
    if (k == 3 && n < 26) return hi + 1;
    return lo + int'($urandom_range(0, hi - lo));
  endfunction

  task automatic send_random();
    int op, imm;
    op = $urandom_range(0, 7);
    case (op)
      4, 5:    imm = pick_imm(9);
      6:       imm = pick_imm(19);
      7:       imm = pick_imm(26);
      default: imm = pick_imm(26);  // ignored by R-type
    endcase
    send_model(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
               imm, $urandom_range(0, 59) == 0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int          op;
    int          rd, rn, rm;
    int          imm;
    bit          last;
    logic [31:0] word;
    bit          ok;
  } vec_t;

  vec_t tbl [14];

  initial begin
    tbl[0]  = '{0,  3,  1,  2,         0, 1'b0, 32'h8B020023, 1'b1};  // ADD
    tbl[1]  = '{4,  9, 22,  0,        64, 1'b0, 32'hF84402C9, 1'b1};  // LDUR +64
    tbl[2]  = '{5,  1,  2,  0,       256, 1'b0, 32'h00000000, 1'b0};  // STUR out of range
    tbl[3]  = '{5,  1,  2,  0,       255, 1'b0, 32'hF80FF041, 1'b1};  // STUR max
    tbl[4]  = '{4,  0, 31,  0,      -256, 1'b0, 32'hF85003E0, 1'b1};  // LDUR min
    tbl[5]  = '{4,  0, 31,  0,      -257, 1'b0, 32'h00000000, 1'b0};  // LDUR below min
    tbl[6]  = '{1, 31, 30, 29,         0, 1'b0, 32'hCB1D03DF, 1'b1};  // SUB
    tbl[7]  = '{2,  4,  5,  6, 'h1234567, 1'b0, 32'h8A0600A4, 1'b1};  // AND, imm ignored
    tbl[8]  = '{3,  7,  8,  9,         0, 1'b0, 32'hAA090107, 1'b1};  // ORR
    tbl[9]  = '{6,  5,  0,  0,        -2, 1'b0, 32'hB4FFFFC5, 1'b1};  // CBZ -2
    tbl[10] = '{6,  0,  0,  0,    262143, 1'b0, 32'hB47FFFE0, 1'b1};  // CBZ max
    tbl[11] = '{6,  0,  0,  0,    262144, 1'b0, 32'h00000000, 1'b0};  // CBZ above max
    tbl[12] = '{7,  0,  0,  0, -33554432, 1'b0, 32'h16000000, 1'b1};  // B min
    tbl[13] = '{7,  0,  0,  0,         3, 1'b1, 32'h14000003, 1'b1};  // B +3, last

    ifc.start = 1'b0;  ifc.in_valid = 1'b0;
    put_fields(0, 0, 0, 0, 0, 1'b0);
    ifc4.start = 1'b0; ifc4.in_valid = 1'b0; ifc4.in_op = '0; ifc4.in_rd = '0;
    ifc4.in_rn = '0;   ifc4.in_rm = '0;      ifc4.in_imm = '0; ifc4.in_last = 1'b0;
    model_clear();
    m_load = 1'b0;

    // ---- reset state ----
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_imem_we",    32'(ifc.imem_we),    0);
    check("rst_imem_wdata", ifc.imem_wdata,      0);
    check("rst_dut4_ready", 32'(ifc4.in_ready),  0);
    check_status("rst");
    reset = 1'b0;

    // IDLE ignores bundles
    send_model(0, 1, 2, 3, 0, 1'b0);
    idle(1);
    check_status("idle");

    // ---- table: back-to-back, one bundle per cycle ----
    do_start(1'b0);
    check_status("start");
    for (int i = 0; i < 14; i++) begin
      send(tbl[i].op, tbl[i].rd, tbl[i].rn, tbl[i].rm, tbl[i].imm, tbl[i].last,
           tbl[i].word, tbl[i].ok);
      check($sformatf("tbl%0d_err_range", i), 32'(ifc.err_range), 32'(m_err_range));
    end
    idle(2);
    check_status("tbl_end");
    check("tbl_count_const", 32'(ifc.count), 11);
    check("tbl_done_const",  32'(ifc.done),  1);

    // DONE holds: nothing accepted
    send_model(0, 1, 1, 1, 0, 1'b0);
    idle(1);
    check_status("done_hold");

    // ---- restart with a dropped bundle ----
    do_start(1'b1);
    idle(1);
    check_status("restart");

    // ---- fill the 64-word instance ----
    for (int i = 0; i < WORDS; i++) send_model(i % 4, i % 32, (i + 1) % 32, (i + 2) % 32, 0, 1'b0);
    send_model(0, 1, 1, 1, 0, 1'b0);
    idle(2);
    check_status("full64");
    check("full64_err_full_const", 32'(ifc.err_full), 1);

    // ---- randomized phase ----
    do_start(1'b0);
    for (int it = 0; it < 600; it++) begin
      int r;
      if (!m_load) begin
        idle(1);
        check_status("rand_stop");
        do_start(1'($urandom_range(0, 1)));
      end
      r = $urandom_range(0, 99);
      if (r < 2) begin
        do_start(1'b1);
      end else if (r < 8) begin
        idle($urandom_range(1, 3));
        check_status("rand_idle");
      end else begin
        send_random();
      end
    end
    idle(2);
    check_status("rand_end");

    // ---- reset mid-load: accept, then reset with a second bundle ----
    do_start(1'b0);
    send_model(0, 3, 1, 2, 0, 1'b0);
    reset        = 1'b1;
    ifc.in_valid = 1'b1;
    put_fields(1, 4, 4, 4, 0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    ifc.in_valid = 1'b0;
    model_clear();
    m_load = 1'b0;
    check("midrst_imem_we",    32'(ifc.imem_we), 0);
    check("midrst_imem_wdata", ifc.imem_wdata,   0);
    check_status("midrst");

    // ---- 4-word instance: overflow without in_last ----
    ifc4.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ifc4.start = 1'b0;
    w4 = 0;
    for (int i = 0; i < 5; i++) begin
      ifc4.in_valid = 1'b1;
      ifc4.in_rd    = 5'(i);
      ifc4.in_rn    = 5'd1;
      ifc4.in_rm    = 5'd2;
      check($sformatf("full4_ready_%0d", i), 32'(ifc4.in_ready), (i < 4) ? 1 : 0);
      @(posedge clk);
      @(negedge clk);
    end
    ifc4.in_valid = 1'b0;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    check("full4_writes",   32'(w4),             4);
    check("full4_err_full", 32'(ifc4.err_full),  1);
    check("full4_done",     32'(ifc4.done),      0);
    check("full4_count",    32'(ifc4.count),     4);
    check("full4_in_ready", 32'(ifc4.in_ready),  0);

    ifc4.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ifc4.start = 1'b0;
    check("full4_restart_ready",    32'(ifc4.in_ready),  1);
    check("full4_restart_addr",     32'(ifc4.imem_addr), 0);
    check("full4_restart_count",    32'(ifc4.count),     0);
    check("full4_restart_err_full", 32'(ifc4.err_full),  0);

    // ---- 4-word instance: in_last on the final word wins over full ----
    for (int i = 0; i < 4; i++) begin
      ifc4.in_valid = 1'b1;
      ifc4.in_last  = (i == 3);
      check($sformatf("last4_ready_%0d", i), 32'(ifc4.in_ready), 1);
      @(posedge clk);
      @(negedge clk);
    end
    ifc4.in_valid = 1'b0;
    ifc4.in_last  = 1'b0;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    check("last4_writes",   32'(w4),            8);
    check("last4_done",     32'(ifc4.done),     1);
    check("last4_err_full", 32'(ifc4.err_full), 0);
    check("last4_count",    32'(ifc4.count),    4);
    check("last4_in_ready", 32'(ifc4.in_ready), 0);

    check("pending_writes", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
